adc_unpack_ch: RTL and testbench

Two-channel receive-side sample unpacker, the counterpart of the DAC packing FIFO. Each channel accepts wide ADC words carrying DW/WW packed samples, buffers them in a small word FIFO, and emits one WW-bit sample per accepted handshake to the downstream DSP chain. Both sides run on one clock. The ADC source has no backpressure, so words arriving while a channel buffer is full are dropped and flagged.

---
 rtl/adc_unpack_pkg.sv | 15 +
 rtl/adc_unpack.sv | 110 +++++++++++
 rtl/adc_unpack_ch.sv | 44 ++++
 tb/tb_adc_unpack_ch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_unpack_pkg.sv
// adc_unpack_pkg: shared sizes and output-stage state for the ADC unpacker.
// Build option: ADC_UNPACK_MSB_FIRST_EN selects MSB-first sample order.
package adc_unpack_pkg;
  localparam int WW    = 16;
  localparam int DW    = 64;
  localparam int DD    = 8;
  localparam int R     = DW / WW;
  localparam int IDX_W = $clog2(R);
  localparam int PTR_W = $clog2(DD) + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } ostate_t;
endpackage

// File: rtl/adc_unpack.sv
// adc_unpack: one channel - word FIFO, shifting output stage, sticky overflow.
// Build option: ADC_UNPACK_MSB_FIRST_EN emits samples MSB-first.
module adc_unpack
  import adc_unpack_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_din_valid,
  input  logic [DW-1:0] i_din_data,
  output logic          o_dout_valid,
  output logic [WW-1:0] o_dout_data,
  input  logic          i_dout_ready,
  output logic          o_ovf
);

  logic [DW-1:0]    r_mem [DD];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [DW-1:0]    r_word;
  logic             r_ovf;
  ostate_t          r_state;

  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_hs;
  logic             w_last;
  logic             w_pop;
  logic             w_push;
  logic [DW-1:0]    w_rd_word;
  logic [DW-1:0]    w_shift;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == PTR_W'(DD));
  assign w_hs      = (r_state == HOLD) && i_dout_ready;
  assign w_last    = (r_idx == IDX_W'(R - 1));
  assign w_pop     = !w_empty &&
                     ((r_state == EMPTY) || (w_hs && w_last));
  assign w_push    = i_din_valid && (!w_full || w_pop);
  assign w_rd_word = r_mem[r_rd_ptr[PTR_W-2:0]];

`ifdef ADC_UNPACK_MSB_FIRST_EN
  assign w_shift     = r_word << WW;
  assign o_dout_data = r_word[DW-1 -: WW];
`else
  assign w_shift     = r_word >> WW;
  assign o_dout_data = r_word[WW-1:0];
`endif

  assign o_dout_valid = (r_state == HOLD);
  assign o_ovf        = r_ovf;

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr[PTR_W-2:0]] <= i_din_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_din_valid && !w_push)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_pop) begin
            r_word  <= w_rd_word;
            r_idx   <= '0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_hs) begin
            if (!w_last) begin
              r_idx  <= r_idx + 1'b1;
              r_word <= w_shift;
            end else if (w_pop) begin
              r_word <= w_rd_word;
              r_idx  <= '0;
            end else begin
              r_word  <= w_shift;
              r_idx   <= '0;
              r_state <= EMPTY;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/adc_unpack_ch.sv
// adc_unpack_ch: two independent ADC sample unpacking channels.
// Build option: ADC_UNPACK_MSB_FIRST_EN emits samples MSB-first.
module adc_unpack_ch
  import adc_unpack_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid_0,
  input  logic [DW-1:0] din_data_0,
  output logic          dout_valid_0,
  output logic [WW-1:0] dout_data_0,
  input  logic          dout_ready_0,
  output logic          ovf_0,
  input  logic          din_valid_1,
  input  logic [DW-1:0] din_data_1,
  output logic          dout_valid_1,
  output logic [WW-1:0] dout_data_1,
  input  logic          dout_ready_1,
  output logic          ovf_1
);

  adc_unpack u_ch0 (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_din_valid  (din_valid_0),
    .i_din_data   (din_data_0),
    .o_dout_valid (dout_valid_0),
    .o_dout_data  (dout_data_0),
    .i_dout_ready (dout_ready_0),
    .o_ovf        (ovf_0)
  );

  adc_unpack u_ch1 (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_din_valid  (din_valid_1),
    .i_din_data   (din_data_1),
    .o_dout_valid (dout_valid_1),
    .o_dout_data  (dout_data_1),
    .i_dout_ready (dout_ready_1),
    .o_ovf        (ovf_1)
  );

endmodule

// File: tb/tb_adc_unpack_ch.sv
// tb_adc_unpack_ch: directed checks of sample order, flow control and overflow.
// Build option: ADC_UNPACK_MSB_FIRST_EN flips the expected sample order.
module tb_adc_unpack_ch;
  import adc_unpack_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid_0 = 1'b0;
  logic [DW-1:0] din_data_0 = '0;
  logic          dout_valid_0;
  logic [WW-1:0] dout_data_0;
  logic          dout_ready_0 = 1'b0;
  logic          ovf_0;
  logic          din_valid_1 = 1'b0;
  logic [DW-1:0] din_data_1 = '0;
  logic          dout_valid_1;
  logic [WW-1:0] dout_data_1;
  logic          dout_ready_1 = 1'b0;
  logic          ovf_1;

  int checks = 0;
  int errors = 0;

  adc_unpack_ch dut (
    .clk          (clk),
    .rst          (rst),
    .din_valid_0  (din_valid_0),
    .din_data_0   (din_data_0),
    .dout_valid_0 (dout_valid_0),
    .dout_data_0  (dout_data_0),
    .dout_ready_0 (dout_ready_0),
    .ovf_0        (ovf_0),
    .din_valid_1  (din_valid_1),
    .din_data_1   (din_data_1),
    .dout_valid_1 (dout_valid_1),
    .dout_data_1  (dout_data_1),
    .dout_ready_1 (dout_ready_1),
    .ovf_1        (ovf_1)
  );

  always #5 clk = ~clk;

  // Word whose sample at bit position j is base + j.
  function automatic logic [DW-1:0] mkw(input logic [WW-1:0] base);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < R; j++)
      w[j*WW +: WW] = base + WW'(j);
    return w;
  endfunction

  // Expected k-th emitted sample of mkw(base).
  function automatic logic [WW-1:0] smp(input logic [WW-1:0] base,
                                         input int k);
`ifdef ADC_UNPACK_MSB_FIRST_EN
    return base + WW'(R - 1 - k);
`else
    return base + WW'(k);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain(input int first, input int n);
    for (int w = first; w < first + n; w++) begin
      for (int k = 0; k < R; k++) begin
        chk("drain_valid", 64'(dout_valid_0), 64'd1);
        chk("drain_data", 64'(dout_data_0), 64'(smp(WW'(w * 16), k)));
        step();
      end
    end
  endtask

  initial begin
    // Reset
    repeat (2) step();
    chk("rst_valid0", 64'(dout_valid_0), 64'd0);
    chk("rst_data0", 64'(dout_data_0), 64'd0);
    chk("rst_ovf0", 64'(ovf_0), 64'd0);
    chk("rst_valid1", 64'(dout_valid_1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single word on ch0, concurrent different word on ch1
    dout_ready_0 = 1'b1;
    dout_ready_1 = 1'b1;
    din_valid_0 = 1'b1;
    din_data_0  = 64'h0004_0003_0002_0001;
    din_valid_1 = 1'b1;
    din_data_1  = mkw(16'h5550);
    step();
    din_valid_0 = 1'b0;
    din_valid_1 = 1'b0;
    chk("lat_valid0", 64'(dout_valid_0), 64'd0);
    step();
    for (int k = 0; k < R; k++) begin
      chk("single_valid0", 64'(dout_valid_0), 64'd1);
      chk("single_data0", 64'(dout_data_0), 64'(smp(16'h0001, k)));
      chk("single_valid1", 64'(dout_valid_1), 64'd1);
      chk("single_data1", 64'(dout_data_1), 64'(smp(16'h5550, k)));
      step();
    end
    chk("single_end0", 64'(dout_valid_0), 64'd0);
    chk("single_end1", 64'(dout_valid_1), 64'd0);
    chk("single_ovf0", 64'(ovf_0), 64'd0);
    chk("single_ovf1", 64'(ovf_1), 64'd0);

    // Back-to-back: one word every 4 cycles, no bubble
    for (int c = 0; c < 14; c++) begin
      din_valid_0 = (c % 4 == 0) && (c <= 8);
      din_data_0  = mkw(WW'(16'h20 + 16 * (c / 4)));
      step();
      if (c >= 1 && c <= 12) begin
        chk("b2b_valid", 64'(dout_valid_0), 64'd1);
        chk("b2b_data", 64'(dout_data_0),
            64'(smp(WW'(16'h20 + 16 * ((c - 1) / 4)), (c - 1) % 4)));
      end else if (c == 13) begin
        chk("b2b_end", 64'(dout_valid_0), 64'd0);
      end
    end
    din_valid_0 = 1'b0;

    // Full FIFO with push on the popping edge
    dout_ready_0 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      din_valid_0 = 1'b1;
      din_data_0  = mkw(WW'(i * 16));
      step();
    end
    din_valid_0 = 1'b0;
    chk("full_ovf", 64'(ovf_0), 64'd0);
    dout_ready_0 = 1'b1;
    for (int k = 0; k < R; k++) begin
      chk("full_hold", 64'(dout_data_0), 64'(smp(16'h10, k)));
      if (k == R - 1) begin
        din_valid_0 = 1'b1;
        din_data_0  = mkw(16'hA0);
      end
      step();
      din_valid_0 = 1'b0;
    end
    chk("fullpop_ovf", 64'(ovf_0), 64'd0);
    drain(2, 9);
    chk("fullpop_end", 64'(dout_valid_0), 64'd0);

    // Backpressure and overflow: 10 pushes, 9 kept
    dout_ready_0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      din_valid_0 = 1'b1;
      din_data_0  = mkw(WW'(i * 16));
      step();
      if (i == 1)
        chk("bp_hold_v", 64'(dout_valid_0), 64'd0);
      if (i == 9)
        chk("ovf_before", 64'(ovf_0), 64'd0);
      if (i == 10)
        chk("ovf_after", 64'(ovf_0), 64'd1);
    end
    din_valid_0 = 1'b0;
    step();
    chk("bp_stall_d", 64'(dout_data_0), 64'(smp(16'h10, 0)));
    dout_ready_0 = 1'b1;
    drain(1, 9);
    chk("ovf_drain_end", 64'(dout_valid_0), 64'd0);
    chk("ovf_sticky", 64'(ovf_0), 64'd1);
    chk("ovf_iso1", 64'(ovf_1), 64'd0);
    chk("iso_valid1", 64'(dout_valid_1), 64'd0);

    // Reset mid-stream
    din_valid_0 = 1'b1;
    din_data_0  = mkw(16'hB0);
    step();
    din_data_0  = mkw(16'hC0);
    step();
    din_valid_0 = 1'b0;
    step();
    step();
    chk("mid_data", 64'(dout_data_0), 64'(smp(16'hB0, 2)));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(dout_valid_0), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_0), 64'd0);
    chk("mid_rst_data", 64'(dout_data_0), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_valid", 64'(dout_valid_0), 64'd0);
    end
    chk("post_rst_ovf", 64'(ovf_0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
